// File: rtl/conv1d_stream_pe.sv
// conv1d_stream_pe: streaming multi-channel 1-D convolution PE with stride, row framing, round/saturate.
// Define RELU_EN to clamp negative results to zero before they are presented.
module conv1d_stream_pe #(
    parameter int WORDWIDTH = 16,
    parameter int NUM2      = 5,
    parameter int CHANNEL   = 2,
    parameter int FRAC      = 8,
    parameter int STRIDE_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              round_mode,
    input  logic [STRIDE_W-1:0]               stride,
    input  logic                              w_load,
    input  logic [CHANNEL*NUM2*WORDWIDTH-1:0] w_in,
    input  logic                              act_valid,
    output logic                              act_ready,
    input  logic [CHANNEL*WORDWIDTH-1:0]      act_in,
    input  logic                              act_last,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [WORDWIDTH-1:0]              res_data,
    output logic                              res_last,
    output logic                              busy
);
    localparam int TW = NUM2 * WORDWIDTH;
    localparam int AW = 2 * WORDWIDTH + $clog2(CHANNEL * NUM2);
    localparam int FW = $clog2(NUM2 + 1);
    localparam logic signed [AW:0] MAXV = {{(AW-WORDWIDTH+2){1'b0}}, {(WORDWIDTH-1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW-WORDWIDTH+2){1'b1}}, {(WORDWIDTH-1){1'b0}}};

    logic [CHANNEL*TW-1:0] w_q, w_eff, x_q, x_n;
    logic [FW-1:0]         fill, fill_n;
    logic [STRIDE_W-1:0]   phase, stride_q, stride_cur;
    logic                  idle, accept, emit;
    logic signed [AW-1:0]  acc;
    logic signed [AW:0]    rnd, shr;
    logic [WORDWIDTH-1:0]  sat, res_n;

    assign idle       = fill == '0 && !res_valid;
    assign busy       = !idle;
    assign act_ready  = !res_valid || res_ready;
    assign accept     = act_valid && act_ready;
    assign w_eff      = idle && w_load ? w_in : w_q;
    assign fill_n     = fill == FW'(NUM2) ? fill : fill + FW'(1);
    assign emit       = accept && fill_n == FW'(NUM2) && phase == '0;
    assign stride_cur = fill != '0 ? stride_q : stride == '0 ? STRIDE_W'(1) : stride;

    // The product sums over the window as it will be after this beat shifts in.
    always_comb begin
        x_n = x_q;
        acc = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            x_n[c*TW +: TW] = {act_in[c*WORDWIDTH +: WORDWIDTH], x_q[c*TW+WORDWIDTH +: TW-WORDWIDTH]};
            for (int j = 0; j < NUM2; j++)
                acc = acc + AW'($signed(w_eff[(c*NUM2+j)*WORDWIDTH +: WORDWIDTH]))
                          * AW'($signed(x_n[(c*NUM2+j)*WORDWIDTH +: WORDWIDTH]));
        end
    end

    assign rnd = (AW+1)'(acc) + ({{AW{1'b0}}, round_mode} << (FRAC - 1));
    assign shr = rnd >>> FRAC;
    assign sat = shr > MAXV ? MAXV[WORDWIDTH-1:0] : shr < MINV ? MINV[WORDWIDTH-1:0] : shr[WORDWIDTH-1:0];
`ifdef RELU_EN
    assign res_n = sat[WORDWIDTH-1] ? '0 : sat;
`else
    assign res_n = sat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q       <= '0;
            x_q       <= '0;
            fill      <= '0;
            phase     <= '0;
            stride_q  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
        end else begin
            if (idle && w_load)
                w_q <= w_in;
            if (accept) begin
                x_q   <= x_n;
                fill  <= act_last ? '0 : fill_n;
                phase <= act_last ? '0 : emit ? stride_cur - STRIDE_W'(1) : phase == '0 ? phase : phase - STRIDE_W'(1);
                if (fill == '0)
                    stride_q <= stride_cur;
            end
            if (emit) begin
                res_valid <= 1'b1;
                res_data  <= res_n;
                res_last  <= act_last;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv1d_stream_pe.sv
// tb_conv1d_stream_pe: randomized self-checking bench for conv1d_stream_pe.
// Expected results come from a sample-history model: a window is emitted at beats NUM2, NUM2+s, NUM2+2s, ...
module tb_conv1d_stream_pe;
    localparam int W = 16, N = 5, C = 2, F = 8, SW = 4;
    typedef struct { longint d; bit l; int due; } res_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          round_mode = 1'b0, w_load = 1'b0, act_valid = 1'b0, act_last = 1'b0, res_ready = 1'b1;
    logic [SW-1:0] stride = SW'(1);
    logic [C*N*W-1:0] w_in = '0, w_next = '0;
    logic [C*W-1:0]   act_in = '0;
    logic          act_ready, res_valid, res_last, busy;
    logic [W-1:0]  res_data;

    int     nvec = 0, nbad = 0, cyc = 0, nrow = 0, srow = 1;
    longint wm[C][N];
    longint hist[C][N];
    res_t   q[$];
    bit     rnd_bp = 1'b0;

    conv1d_stream_pe #(.WORDWIDTH(W), .NUM2(N), .CHANNEL(C), .FRAC(F), .STRIDE_W(SW)) dut (
        .clk(clk), .rst(rst), .round_mode(round_mode), .stride(stride), .w_load(w_load), .w_in(w_in),
        .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in), .act_last(act_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [C*N*W-1:0] wfill(input longint v0, input longint v1, input bit tap0only);
        logic [C*N*W-1:0] r = '0;
        for (int c = 0; c < C; c++)
            for (int j = 0; j < N; j++)
                r[(c*N+j)*W +: W] = (tap0only && j != 0) ? W'(0) : W'(c == 0 ? v0 : v1);
        return r;
    endfunction

    function automatic logic [C*W-1:0] apack(input longint a0, input longint a1);
        return {W'(a1), W'(a0)};
    endfunction

    function automatic logic [W-1:0] rw(input int lim);
        return W'(int'($urandom_range(0, 2 * lim)) - lim);
    endfunction

    task automatic model_accept(input logic [C*W-1:0] pv, input bit last);
        longint a = 0;
        if (w_load && nrow == 0 && q.size() == 0)
            for (int c = 0; c < C; c++)
                for (int j = 0; j < N; j++)
                    wm[c][j] = longint'($signed(w_in[(c*N+j)*W +: W]));
        if (nrow == 0) srow = stride == 0 ? 1 : int'(stride);
        nrow++;
        for (int c = 0; c < C; c++) begin
            for (int j = 0; j < N - 1; j++) hist[c][j] = hist[c][j+1];
            hist[c][N-1] = longint'($signed(pv[c*W +: W]));
        end
        if (nrow >= N && (nrow - N) % srow == 0) begin
            for (int c = 0; c < C; c++)
                for (int j = 0; j < N; j++)
                    a += wm[c][j] * hist[c][j];
            a = (a + (round_mode ? (longint'(1) << (F - 1)) : longint'(0))) >>> F;
            if (a > 32767) a = 32767;
            else if (a < -32768) a = -32768;
`ifdef RELU_EN
            if (a < 0) a = 0;
`endif
            q.push_back('{a, last, cyc + 1});
        end
        if (last) nrow = 0;
    endtask

    task automatic beat(input logic [C*W-1:0] pv, input bit last, input bit rm, input bit wl, input logic [SW-1:0] st);
        int t = 0;
        @(negedge clk);
        act_valid = 1'b1; act_in = pv; act_last = last; round_mode = rm; w_load = wl; stride = st;
        if (wl) w_in = w_next;
        #1;
        while (!act_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!act_ready) chk("act_ready_timeout", 0, 1);
        else model_accept(pv, last);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        act_valid = 1'b0; act_last = 1'b0; w_load = 1'b0;
    endtask

    task automatic load_w(input logic [C*N*W-1:0] wv);
        @(negedge clk);
        act_valid = 1'b0; w_in = wv; w_load = 1'b1;
        #1;
        if (nrow == 0 && q.size() == 0)
            for (int c = 0; c < C; c++)
                for (int j = 0; j < N; j++)
                    wm[c][j] = longint'($signed(wv[(c*N+j)*W +: W]));
        @(negedge clk);
        w_load = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        act_valid = 1'b0; act_last = 1'b0; w_load = 1'b0; res_ready = 1'b1;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
        chk("idle_busy", busy, nrow != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; act_valid = 1'b0; act_last = 1'b0; w_load = 1'b0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_act_ready", act_ready, 1);
        q.delete();
        nrow = 0;
        for (int c = 0; c < C; c++)
            for (int j = 0; j < N; j++) wm[c][j] = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Result monitor: validity timing, data/last against the model queue, stability under backpressure.
    initial forever begin
        bit exp_v;
        @(negedge clk);
        #2;
        if (!rst) begin
            exp_v = (q.size() > 0) ? (q[0].due <= cyc) : 1'b0;
            chk("res_valid", res_valid, exp_v);
            chk("act_ready", act_ready, !exp_v || res_ready);
            if (res_valid && q.size() > 0) begin
                chk("res_data", longint'($signed(res_data)), q[0].d);
                chk("res_last", res_last, q[0].l);
                if (res_ready) void'(q.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rnd_bp) res_ready = ($urandom_range(3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [SW-1:0] st;
        bit wl;
        logic [C*W-1:0] pv;
        do_reset();
        // unity sum
        load_w(wfill(256, 256, 0));
        for (int k = 1; k <= 5; k++) beat(apack(256, 256), k == 5, 0, 0, 1);
        drain();
        // stride 2 row of nine ramp samples
        load_w(wfill(256, 0, 0));
        for (int k = 1; k <= 9; k++) beat(apack(k * 256, 77), k == 9, 0, 0, 2);
        drain();
        // rounding on +/-3 through a single 0.5 tap
        load_w(wfill(128, 0, 1));
        for (int s = 0; s < 4; s++) begin
            for (int k = 1; k <= 5; k++)
                beat(apack(k == 1 ? (s < 2 ? 3 : -3) : 0, 0), k == 5, s[0], 0, 1);
            drain();
        end
        // saturation both ways
        load_w(wfill(256, 256, 0));
        for (int k = 1; k <= 5; k++) beat(apack(32512, 32512), k == 5, 0, 0, 1);
        drain();
        load_w(wfill(-256, -256, 0));
        for (int k = 1; k <= 5; k++) beat(apack(32512, 32512), k == 5, 1, 0, 1);
        drain();
        // backpressure: hold the first result for many cycles, then stream
        load_w(wfill(100, -40, 0));
        @(negedge clk);
        res_ready = 1'b0;
        fork
            for (int k = 1; k <= 9; k++) beat(apack(k * 300, -k * 120), k == 9, 0, 0, 1);
            begin
                repeat (16) @(negedge clk);
                chk("bp_stall", act_ready, 0);
                @(negedge clk);
                res_ready = 1'b1;
            end
        join
        drain();
        // reset mid-row, then a full unity row
        for (int k = 1; k <= 3; k++) beat(apack(256, 256), 0, 0, 0, 1);
        do_reset();
        load_w(wfill(256, 256, 0));
        for (int k = 1; k <= 5; k++) beat(apack(256, 256), k == 5, 0, 0, 1);
        drain();
        // short row yields nothing
        for (int k = 1; k <= 3; k++) beat(apack(999, 999), k == 3, 0, 0, 1);
        drain();
        // weight load during a row is ignored
        for (int k = 1; k <= 2; k++) beat(apack(256, 256), 0, 0, 0, 1);
        load_w(wfill(-7, 13, 0));
        chk("busy_mid_row", busy, 1);
        for (int k = 3; k <= 6; k++) beat(apack(256, 512), k == 6, 0, 0, 1);
        drain();
        // randomized rows with stride changes, gaps, weight loads and backpressure
        rnd_bp = 1'b1;
        for (int r = 0; r < 150; r++) begin
            len = $urandom_range(1, 12);
            st = SW'($urandom_range(0, 3));
            wl = ($urandom_range(3) == 0);
            for (int i = 0; i < C * N; i++) w_next[i*W +: W] = ($urandom_range(7) == 0) ? rw(32767) : rw(512);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(4) == 0) idle_cycle();
                for (int c = 0; c < C; c++) pv[c*W +: W] = ($urandom_range(3) == 0) ? rw(32767) : rw(2000);
                beat(pv, k == len - 1, 1'($urandom_range(1)), wl && k == 0, k == 0 ? st : SW'($urandom));
            end
        end
        rnd_bp = 1'b0;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
